// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with an iterative multiply/divide unit.
//
// Single-cycle logic, arithmetic, shift and compare operations produce
// o_alu_result combinationally. MULT/MULTU/DIV/DIVU run over N_BITS CALC
// cycles plus one SIGN cycle, then present HI/LO with a one-cycle o_done.
// MTHI/MTLO write HI/LO directly. MFHI/MFLO read HI/LO combinationally.
//
// Ports:
//   i_clock       clock, all state on rising edge
//   i_reset       synchronous active-high reset
//   i_dato_A      operand A (rs, also shift amount)
//   i_dato_B      operand B (rt or immediate)
//   i_alu_ctrl    operation code, bit 4 selects the HI/LO class
//   i_start       valid strobe for MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   o_alu_result  combinational result
//   o_alu_zero    o_alu_result == 0
//   o_overflow    signed overflow for ADD/SUB
//   o_busy        multiply/divide in progress
//   o_done        one-cycle pulse, HI/LO valid
//   o_div_zero    pulses with o_done when the divisor was zero
//   o_stall       busy while a HI/LO-class op is presented
module alu_muldiv #(
    parameter int N_BITS         = 32,
    parameter int N_BITS_CONTROL = 5
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [N_BITS-1:0]         i_dato_A,
    input  logic [N_BITS-1:0]         i_dato_B,
    input  logic [N_BITS_CONTROL-1:0] i_alu_ctrl,
    input  logic                      i_start,
    output logic [N_BITS-1:0]         o_alu_result,
    output logic                      o_alu_zero,
    output logic                      o_overflow,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_div_zero,
    output logic                      o_stall
);

    localparam int ShW  = $clog2(N_BITS);
    localparam int CntW = ShW + 1;

    localparam logic [N_BITS_CONTROL-1:0] OpAnd   = N_BITS_CONTROL'(5'b00000);
    localparam logic [N_BITS_CONTROL-1:0] OpOr    = N_BITS_CONTROL'(5'b00001);
    localparam logic [N_BITS_CONTROL-1:0] OpAdd   = N_BITS_CONTROL'(5'b00010);
    localparam logic [N_BITS_CONTROL-1:0] OpNor   = N_BITS_CONTROL'(5'b00011);
    localparam logic [N_BITS_CONTROL-1:0] OpXor   = N_BITS_CONTROL'(5'b00100);
    localparam logic [N_BITS_CONTROL-1:0] OpSll   = N_BITS_CONTROL'(5'b00101);
    localparam logic [N_BITS_CONTROL-1:0] OpSub   = N_BITS_CONTROL'(5'b00110);
    localparam logic [N_BITS_CONTROL-1:0] OpSlt   = N_BITS_CONTROL'(5'b00111);
    localparam logic [N_BITS_CONTROL-1:0] OpSrl   = N_BITS_CONTROL'(5'b01000);
    localparam logic [N_BITS_CONTROL-1:0] OpSra   = N_BITS_CONTROL'(5'b01001);
    localparam logic [N_BITS_CONTROL-1:0] OpSltu  = N_BITS_CONTROL'(5'b01010);
    localparam logic [N_BITS_CONTROL-1:0] OpMult  = N_BITS_CONTROL'(5'b10000);
    localparam logic [N_BITS_CONTROL-1:0] OpMultu = N_BITS_CONTROL'(5'b10001);
    localparam logic [N_BITS_CONTROL-1:0] OpDiv   = N_BITS_CONTROL'(5'b10010);
    localparam logic [N_BITS_CONTROL-1:0] OpDivu  = N_BITS_CONTROL'(5'b10011);
    localparam logic [N_BITS_CONTROL-1:0] OpMfhi  = N_BITS_CONTROL'(5'b10100);
    localparam logic [N_BITS_CONTROL-1:0] OpMflo  = N_BITS_CONTROL'(5'b10101);
    localparam logic [N_BITS_CONTROL-1:0] OpMthi  = N_BITS_CONTROL'(5'b10110);
    localparam logic [N_BITS_CONTROL-1:0] OpMtlo  = N_BITS_CONTROL'(5'b10111);

    typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

    state_e            state_q, state_d;
    logic [N_BITS-1:0] hi_q, lo_q;
    logic [N_BITS-1:0] acc_q;     // product upper half / partial remainder
    logic [N_BITS-1:0] work_q;    // multiplier shifting out / dividend -> quotient
    logic [N_BITS-1:0] opnd_q;    // multiplicand or divisor magnitude
    logic [CntW-1:0]   cnt_q;
    logic              is_div_q, neg_res_q, neg_rem_q, div_zero_q;

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [N_BITS-1:0] sum, diff;
    logic [ShW-1:0]    shamt;

    always_comb begin
        sum          = i_dato_A + i_dato_B;
        diff         = i_dato_A - i_dato_B;
        shamt        = i_dato_A[ShW-1:0];
        o_alu_result = '0;
        o_overflow   = 1'b0;
        case (i_alu_ctrl)
            OpAnd:  o_alu_result = i_dato_A & i_dato_B;
            OpOr:   o_alu_result = i_dato_A | i_dato_B;
            OpNor:  o_alu_result = ~(i_dato_A | i_dato_B);
            OpXor:  o_alu_result = i_dato_A ^ i_dato_B;
            OpAdd: begin
                o_alu_result = sum;
                o_overflow   = (i_dato_A[N_BITS-1] == i_dato_B[N_BITS-1]) &&
                               (sum[N_BITS-1] != i_dato_A[N_BITS-1]);
            end
            OpSub: begin
                o_alu_result = diff;
                o_overflow   = (i_dato_A[N_BITS-1] != i_dato_B[N_BITS-1]) &&
                               (diff[N_BITS-1] != i_dato_A[N_BITS-1]);
            end
            OpSlt:  o_alu_result = {{(N_BITS-1){1'b0}}, $signed(i_dato_A) < $signed(i_dato_B)};
            OpSltu: o_alu_result = {{(N_BITS-1){1'b0}}, i_dato_A < i_dato_B};
            OpSll:  o_alu_result = i_dato_B << shamt;
            OpSrl:  o_alu_result = i_dato_B >> shamt;
            OpSra:  o_alu_result = $unsigned($signed(i_dato_B) >>> shamt);
            OpMfhi: o_alu_result = hi_q;
            OpMflo: o_alu_result = lo_q;
            default: ;
        endcase
    end

    assign o_alu_zero = (o_alu_result == '0);

    // ------------------------------------------------------------------
    // Start decode and operand magnitudes
    // ------------------------------------------------------------------
    logic              is_muldiv, accept, op_signed, a_neg, b_neg;
    logic [N_BITS-1:0] a_mag, b_mag;

    always_comb begin
        is_muldiv = (i_alu_ctrl == OpMult) || (i_alu_ctrl == OpMultu) ||
                    (i_alu_ctrl == OpDiv)  || (i_alu_ctrl == OpDivu);
        // Busy states (CALC/SIGN) never accept, which also blocks MT writes.
        accept    = i_start && ((state_q == StIdle) || (state_q == StDone));
        op_signed = ~i_alu_ctrl[0];
        a_neg     = op_signed & i_dato_A[N_BITS-1];
        b_neg     = op_signed & i_dato_B[N_BITS-1];
        a_mag     = a_neg ? (~i_dato_A + 1'b1) : i_dato_A;
        b_mag     = b_neg ? (~i_dato_B + 1'b1) : i_dato_B;
    end

    // ------------------------------------------------------------------
    // One iteration: shift-add multiply or restoring divide
    // ------------------------------------------------------------------
    logic [N_BITS:0]   add_sum, sub_shift, sub_diff;
    logic [N_BITS-1:0] acc_step, work_step;

    always_comb begin
        add_sum   = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);
        sub_shift = {acc_q, work_q[N_BITS-1]};
        sub_diff  = sub_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!sub_diff[N_BITS]) begin
                acc_step  = sub_diff[N_BITS-1:0];
                work_step = {work_q[N_BITS-2:0], 1'b1};
            end else begin
                acc_step  = sub_shift[N_BITS-1:0];
                work_step = {work_q[N_BITS-2:0], 1'b0};
            end
        end else begin
            // {carry, acc, work} >> 1: the low product bit falls into work.
            acc_step  = add_sum[N_BITS:1];
            work_step = {add_sum[0], work_q[N_BITS-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction applied in the SIGN state
    // ------------------------------------------------------------------
    logic [2*N_BITS-1:0] prod_fix;
    logic [N_BITS-1:0]   hi_fix, lo_fix;

    always_comb begin
        prod_fix = neg_res_q ? (~{acc_q, work_q} + 1'b1) : {acc_q, work_q};
        if (is_div_q) begin
            // Divide by zero leaves the dividend magnitude in acc, so the
            // remainder sign fix restores the original dividend in HI.
            lo_fix = div_zero_q ? '1 : (neg_res_q ? (~work_q + 1'b1) : work_q);
            hi_fix = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
        end else begin
            hi_fix = prod_fix[2*N_BITS-1:N_BITS];
            lo_fix = prod_fix[N_BITS-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            acc_q      <= '0;
            work_q     <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            if (accept && is_muldiv) begin
                acc_q      <= '0;
                cnt_q      <= CntW'(N_BITS - 1);
                is_div_q   <= i_alu_ctrl[1];
                neg_res_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                div_zero_q <= i_alu_ctrl[1] && (i_dato_B == '0);
                work_q     <= i_alu_ctrl[1] ? a_mag : b_mag;
                opnd_q     <= i_alu_ctrl[1] ? b_mag : a_mag;
            end else if (state_q == StCalc) begin
                acc_q  <= acc_step;
                work_q <= work_step;
                cnt_q  <= cnt_q - 1'b1;
            end

            if (state_q == StSign) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
            end else if (accept && (i_alu_ctrl == OpMthi)) begin
                hi_q <= i_dato_A;
            end else if (accept && (i_alu_ctrl == OpMtlo)) begin
                lo_q <= i_dato_A;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register, next state, outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: state_d = (accept && is_muldiv) ? StCalc : StIdle;
            StCalc:         state_d = (cnt_q == '0) ? StSign : StCalc;
            StSign:         state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        o_busy     = (state_q == StCalc) || (state_q == StSign);
        o_done     = (state_q == StDone);
        o_div_zero = (state_q == StDone) && div_zero_q;
        o_stall    = o_busy && i_alu_ctrl[4];
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (N_BITS=32).
module tb_alu_muldiv;

    localparam logic [4:0] OP_AND = 5'b00000, OP_OR = 5'b00001, OP_ADD = 5'b00010;
    localparam logic [4:0] OP_NOR = 5'b00011, OP_XOR = 5'b00100, OP_SLL = 5'b00101;
    localparam logic [4:0] OP_SUB = 5'b00110, OP_SLT = 5'b00111, OP_SRL = 5'b01000;
    localparam logic [4:0] OP_SRA = 5'b01001, OP_SLTU = 5'b01010;
    localparam logic [4:0] OP_MULT = 5'b10000, OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV = 5'b10010, OP_DIVU = 5'b10011;
    localparam logic [4:0] OP_MFHI = 5'b10100, OP_MFLO = 5'b10101;
    localparam logic [4:0] OP_MTHI = 5'b10110, OP_MTLO = 5'b10111;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b;
    logic [4:0]  ctrl;
    logic [31:0] result;
    logic        zero, ovf, busy, done, div_zero, stall;

    int n_cmp = 0;
    int n_err = 0;

    alu_muldiv #(
        .N_BITS         (32),
        .N_BITS_CONTROL (5)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_dato_A     (a),
        .i_dato_B     (b),
        .i_alu_ctrl   (ctrl),
        .i_start      (start),
        .o_alu_result (result),
        .o_alu_zero   (zero),
        .o_overflow   (ovf),
        .o_busy       (busy),
        .o_done       (done),
        .o_div_zero   (div_zero),
        .o_stall      (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Move to the middle (negedge) of the next cycle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } cvec_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } mvec_t;

    cvec_t ctab [0:19];
    mvec_t mtab [0:8];

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; ctrl = OP_MFHI;
        tick(); tick();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz: got %b want 0", div_zero); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 0", result); end
        ctrl = OP_MFLO; #1;
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 0", result); end
        rst = 1'b0;
    endtask

    task automatic test_comb();
        ctab = '{
            '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1},
            '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0},
            '{OP_ADD,  32'h00000001, 32'h00000002, 32'h00000003, 1'b0},
            '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1},
            '{OP_SUB,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1},
            '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
            '{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0},
            '{OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0},
            '{OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0},
            '{OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0},
            '{OP_SRA,  32'h00000004, 32'h80000000, 32'hF8000000, 1'b0},
            '{OP_SRL,  32'h00000004, 32'h80000000, 32'h08000000, 1'b0},
            '{OP_SLL,  32'h00000024, 32'h00000003, 32'h00000030, 1'b0},
            '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0},
            '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0},
            '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0},
            '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0},
            '{OP_MULT, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0},
            '{5'b01011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0},
            '{OP_SRA,  32'h0000001F, 32'h40000000, 32'h00000000, 1'b0}
        };
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ctrl = ctab[i].op; a = ctab[i].a; b = ctab[i].b;
            #1;
            n_cmp++;
            if (result !== ctab[i].res) begin
                n_err++; $display("FAIL comb_result[%0d]: got %h want %h", i, result, ctab[i].res);
            end
            n_cmp++;
            if (zero !== (ctab[i].res == 32'h0)) begin
                n_err++; $display("FAIL comb_zero[%0d]: got %b want %b", i, zero, ctab[i].res == 32'h0);
            end
            n_cmp++;
            if (ovf !== ctab[i].ovf) begin
                n_err++; $display("FAIL comb_ovf[%0d]: got %b want %b", i, ovf, ctab[i].ovf);
            end
        end
    endtask

    // Each op: busy for cycles 1..33 after the start edge, done in cycle 34;
    // MFHI held meanwhile must stall and show the previous HI.
    task automatic test_muldiv();
        logic [31:0] prev_hi;
        mtab = '{
            '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0},
            '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0},
            '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0},
            '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1},
            '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0},
            '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1},
            '{OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0},
            '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0},
            '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0}
        };
        prev_hi = 32'h0;
        for (int i = 0; i < 9; i++) begin
            tick();
            start = 1'b1; ctrl = mtab[i].op; a = mtab[i].a; b = mtab[i].b;
            for (int j = 1; j <= 34; j++) begin
                tick();
                start = 1'b0; ctrl = OP_MFHI; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A;
                #1;
                n_cmp++;
                if (busy !== (j <= 33)) begin
                    n_err++; $display("FAIL md_busy[%0d] cyc %0d: got %b want %b", i, j, busy, j <= 33);
                end
                n_cmp++;
                if (done !== (j == 34)) begin
                    n_err++; $display("FAIL md_done[%0d] cyc %0d: got %b want %b", i, j, done, j == 34);
                end
                n_cmp++;
                if (stall !== (j <= 33)) begin
                    n_err++; $display("FAIL md_stall[%0d] cyc %0d: got %b want %b", i, j, stall, j <= 33);
                end
                if (j <= 33) begin
                    n_cmp++;
                    if (result !== prev_hi) begin
                        n_err++; $display("FAIL md_old_hi[%0d] cyc %0d: got %h want %h", i, j, result, prev_hi);
                    end
                end
            end
            n_cmp++;
            if (div_zero !== mtab[i].dz) begin
                n_err++; $display("FAIL md_dz[%0d]: got %b want %b", i, div_zero, mtab[i].dz);
            end
            n_cmp++;
            if (result !== mtab[i].hi) begin
                n_err++; $display("FAIL md_hi[%0d]: got %h want %h", i, result, mtab[i].hi);
            end
            ctrl = OP_MFLO; #1;
            n_cmp++;
            if (result !== mtab[i].lo) begin
                n_err++; $display("FAIL md_lo[%0d]: got %h want %h", i, result, mtab[i].lo);
            end
            prev_hi = mtab[i].hi;
        end
    endtask

    // MFLO held across a MULT (old LO is 0xFFFFFFFD); an MTHI issued mid-way is ignored.
    task automatic test_stall_mthi();
        tick();
        start = 1'b1; ctrl = OP_MULT; a = 32'd6; b = 32'd7;
        for (int j = 1; j <= 34; j++) begin
            tick();
            start = (j == 5);
            ctrl  = (j == 5) ? OP_MTHI : OP_MFLO;
            a = 32'hDEADBEEF; b = 32'h0;
            #1;
            n_cmp++;
            if (stall !== (j <= 33)) begin
                n_err++; $display("FAIL stall cyc %0d: got %b want %b", j, stall, j <= 33);
            end
            if (j != 5) begin
                n_cmp++;
                if (result !== ((j <= 33) ? 32'hFFFFFFFD : 32'd42)) begin
                    n_err++; $display("FAIL stall_lo cyc %0d: got %h want %h", j, result,
                                      (j <= 33) ? 32'hFFFFFFFD : 32'd42);
                end
            end
        end
        ctrl = OP_MFHI; #1;
        n_cmp++;
        if (result !== 32'h0) begin n_err++; $display("FAIL mthi_busy_hi: got %h want 0", result); end
    endtask

    task automatic test_mt();
        tick();
        start = 1'b1; ctrl = OP_MTHI; a = 32'h12345678;
        tick();
        start = 1'b0; ctrl = OP_MFHI; a = 32'h0; #1;
        n_cmp++; if (result !== 32'h12345678) begin n_err++; $display("FAIL mthi: got %h want 12345678", result); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mt_busy: got %b want 0", busy); end
        start = 1'b1; ctrl = OP_MTLO; a = 32'hCAFEF00D;
        tick();
        start = 1'b0; ctrl = OP_MFLO; a = 32'h0; #1;
        n_cmp++; if (result !== 32'hCAFEF00D) begin n_err++; $display("FAIL mtlo: got %h want cafef00d", result); end
        ctrl = OP_MFHI; #1;
        n_cmp++; if (result !== 32'h12345678) begin n_err++; $display("FAIL mtlo_hi_kept: got %h want 12345678", result); end
    endtask

    task automatic test_reset_abort();
        logic saw_done;
        tick();
        start = 1'b1; ctrl = OP_DIV; a = 32'd100; b = 32'd3;
        tick();
        start = 1'b0; ctrl = OP_MFLO;
        for (int j = 2; j <= 10; j++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL abort_lo: got %h want 0", result); end
        ctrl = OP_MFHI; #1;
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL abort_hi: got %h want 0", result); end
        saw_done = 1'b0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
        // Reset and start on the same edge: reset wins.
        start = 1'b1; rst = 1'b1; ctrl = OP_MULT; a = 32'd9; b = 32'd9;
        tick();
        start = 1'b0; rst = 1'b0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_vs_start: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        tick();
        start = 1'b1; ctrl = OP_MULT; a = 32'd3; b = 32'd4;
        for (int j = 1; j <= 34; j++) begin
            tick();
            start = 1'b0; ctrl = OP_MFLO;
        end
        #1;
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_first_done: got %b want 1", done); end
        start = 1'b1; ctrl = OP_MULT; a = 32'h00010000; b = 32'h00010000;
        tick();
        start = 1'b0; ctrl = OP_MFLO; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy); end
        n_cmp++; if (result !== 32'd12) begin n_err++; $display("FAIL b2b_first_lo: got %h want c", result); end
        for (int j = 2; j <= 34; j++) begin
            tick();
            #1;
            n_cmp++;
            if (done !== (j == 34)) begin
                n_err++; $display("FAIL b2b_done cyc %0d: got %b want %b", j, done, j == 34);
            end
        end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL b2b_lo: got %h want 0", result); end
        ctrl = OP_MFHI; #1;
        n_cmp++; if (result !== 32'h1) begin n_err++; $display("FAIL b2b_hi: got %h want 1", result); end
    endtask

    initial begin
        test_reset();
        test_comb();
        test_muldiv();
        test_stall_mthi();
        test_mt();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
